multi_8b: RTL and testbench

MULTI_8B -- requirements
Module: multi_8b

---
 rtl/multi_8b.sv | 104 ++++++++++
 tb/tb_multi_8b.sv | 137 +++++++++++++
 2 files changed

// File: rtl/multi_8b.sv
// Sequential 8x8 unsigned shift-add multiplier (IDLE -> CALC -> DONE).
// Optional macro MULTI_8B_EARLY_EXIT_EN: CALC ends as soon as the remaining multiplier is zero.
module multi_8b (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] Result,
  output logic        fimOperacao,
  output logic        Z,
  output logic        OV,
  output logic [1:0]  dbg_state_o
);

  // Handshake: start is accepted only at a rising edge while IDLE, and A/B are
  // captured on that edge. fimOperacao is a one-cycle pulse marking Result/Z/OV as
  // freshly updated; start during CALC or DONE is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] mcand_q;
  logic [7:0]  mplier_q;
  logic [15:0] acc_q;
  logic [2:0]  cnt_q;
  logic [15:0] result_q;
  logic        fim_q;
  logic        z_q;
  logic        ov_q;

  logic [15:0] acc_add_d;
  logic [15:0] acc_d;
  logic        last_d;

  always_comb begin
    acc_add_d = mplier_q[0] ? mcand_q : 16'd0;
    acc_d     = acc_q + acc_add_d;
`ifdef MULTI_8B_EARLY_EXIT_EN
    last_d    = (cnt_q == 3'd7) || (mplier_q[7:1] == 7'd0);
`else
    last_d    = (cnt_q == 3'd7);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      acc_q    <= 16'd0;
      cnt_q    <= 3'd0;
      result_q <= 16'd0;
      fim_q    <= 1'b0;
      z_q      <= 1'b1;
      ov_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          fim_q <= 1'b0;
          if (start) begin
            mcand_q  <= {8'd0, A};
            mplier_q <= B;
            acc_q    <= 16'd0;
            cnt_q    <= 3'd0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[7:1]};
          cnt_q    <= cnt_q + 3'd1;
          if (last_d) begin
            // The final partial product is folded in on this same edge.
            result_q <= acc_d;
            z_q      <= (acc_d == 16'd0);
            ov_q     <= (acc_d[15:8] != 8'd0);
            fim_q    <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          fim_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          fim_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Result      = result_q;
  assign fimOperacao = fim_q;
  assign Z           = z_q;
  assign OV          = ov_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multi_8b.sv
// Bench for multi_8b: directed and random operations checked against an arithmetic model.
module tb_multi_8b;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] Result;
  logic        fimOperacao;
  logic        Z;
  logic        OV;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_pass;
  logic [15:0] exp_q[$];
  logic [15:0] last_res;

  multi_8b dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .Result      (Result),
    .fimOperacao (fimOperacao),
    .Z           (Z),
    .OV          (OV),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic int calc_lat(input logic [7:0] b);
`ifdef MULTI_8B_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
    return l;
`else
    return 8;
`endif
  endfunction

  task automatic check_held(input string tag);
    check({tag, "_fim"}, {31'd0, fimOperacao}, 32'd0);
    check({tag, "_res"}, {16'd0, Result}, {16'd0, last_res});
    check({tag, "_z"},   {31'd0, Z},  {31'd0, (last_res == 16'd0)});
    check({tag, "_ov"},  {31'd0, OV}, {31'd0, (last_res > 16'd255)});
  endtask

  // driver: one full operation; perturb changes A/B and pulses start mid-CALC
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit perturb);
    int lat;
    logic [15:0] exp_p;
    lat = calc_lat(b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    exp_q.push_back(16'(a) * 16'(b));
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (perturb && lat >= 3 && c == 1) begin
        A = 8'($urandom); B = 8'($urandom); start = 1'b1;
      end
      if (c == 2) start = 1'b0;
      if (c < lat) check_held("calc");
    end
    exp_p = exp_q.pop_front();
    check("done_fim", {31'd0, fimOperacao}, 32'd1);
    check("done_res", {16'd0, Result}, {16'd0, exp_p});
    check("done_z",   {31'd0, Z},  {31'd0, (exp_p == 16'd0)});
    check("done_ov",  {31'd0, OV}, {31'd0, (exp_p > 16'd255)});
    last_res = exp_p;
    // pulse is exactly one cycle and no stray second completion follows
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_held("post");
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_res = 16'd0;
    rst = 1'b0; start = 1'b0; A = 8'd0; B = 8'd0;
    #12;
    check_held("reset");
    @(negedge clk);
    rst = 1'b1;

    run_op(8'd0,   8'd0,   1'b0);
    run_op(8'd5,   8'd10,  1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd128, 8'd2,   1'b0);
    run_op(8'd1,   8'd200, 1'b1);
    run_op(8'd77,  8'd129, 1'b1);

    // reset during CALC cycle 4 aborts with no completion
    @(negedge clk);
    A = 8'd200; B = 8'd77; start = 1'b1;
    exp_q.push_back(16'd15400);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    void'(exp_q.pop_front());
    last_res = 16'd0;
    check_held("abort");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_held("idle_after_abort");
    end
    run_op(8'd13, 8'd17, 1'b0);

    for (int i = 0; i < 25; i++)
      run_op(8'($urandom), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
